// File: rtl/fn3_pkg.sv
// fn3_pkg: shared constants, types and the reference 3-input function
// used by the round-robin scheduler and its bench.
package fn3_pkg;

    // Function select encodings carried on req_sel.
    localparam logic FN_PARITY = 1'b0;
    localparam logic FN_AND3   = 1'b1;

    // Response register occupancy.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } rsp_state_t;

    // Parity for FN_PARITY, three-way AND for FN_AND3.
    function automatic logic fn3_eval(
        input logic a,
        input logic b,
        input logic c,
        input logic sel
    );
        return (sel == FN_AND3) ? (a & b & c) : (a ^ b ^ c);
    endfunction

endpackage

// File: rtl/fn3_unit.sv
// fn3_unit: combinational 3-input function unit (parity / AND3).
// Ports: a, b, c operands; sel function select; o1 result.
module fn3_unit
    import fn3_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic sel,
    output logic o1
);

    // Kept as its own module so a gate-level version can drop in.
    assign o1 = fn3_eval(a, b, c, sel);

endmodule

// File: rtl/fn3_rr_sched.sv
// fn3_rr_sched: round-robin share of one fn3_unit among N_REQ requesters,
// with a registered, backpressured response. Optional grant counters
// are built when the FN3_SCHED_STATS_EN macro is defined.
// Ports: clk, rst_n (async, active-low); req_valid/req_ready handshake
// with req_a/b/c/sel operands; rsp_valid/rsp_ready with rsp_o1, rsp_id;
// gnt_cnt (stats build only) packs one CNT_W counter per requester.
module fn3_rr_sched
    import fn3_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int CNT_W = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ-1:0]          req_a,
    input  logic [N_REQ-1:0]          req_b,
    input  logic [N_REQ-1:0]          req_c,
    input  logic [N_REQ-1:0]          req_sel,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_o1,
    output logic [$clog2(N_REQ)-1:0]  rsp_id
`ifdef FN3_SCHED_STATS_EN
    ,
    output logic [N_REQ*CNT_W-1:0]    gnt_cnt
`endif
);

    localparam int ID_W = $clog2(N_REQ);

    rsp_state_t      state_q;
    rsp_state_t      state_d;

    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] win;
    logic [ID_W-1:0] nxt_ptr;
    logic            found;
    logic            can_accept;
    logic            grant;

    logic            win_a;
    logic            win_b;
    logic            win_c;
    logic            win_sel;
    logic            fn_o1;

    assign rsp_valid  = (state_q == ST_FULL);
    assign can_accept = !rsp_valid || rsp_ready;

    // Scan req_valid starting at ptr, wrapping; first hit wins.
    always_comb begin
        logic [ID_W-1:0] cand;
        int              j;
        win   = '0;
        found = 1'b0;
        cand  = '0;
        j     = 0;
        for (int i = 0; i < N_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            cand = ID_W'(j);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // rst_n gates the grant so nothing is accepted while in reset.
    assign grant     = rst_n && can_accept && found;
    assign req_ready = grant ? (N_REQ'(1) << win) : '0;

    assign nxt_ptr = (win == ID_W'(N_REQ - 1)) ? '0 : win + ID_W'(1);

    assign win_a   = req_a[win];
    assign win_b   = req_b[win];
    assign win_c   = req_c[win];
    assign win_sel = req_sel[win];

    fn3_unit u_fn3 (
        .a   (win_a),
        .b   (win_b),
        .c   (win_c),
        .sel (win_sel),
        .o1  (fn_o1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // A grant always (re)fills the register, even while draining.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (grant) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (grant) begin
                    state_d = ST_FULL;
                end else if (rsp_ready) begin
                    state_d = ST_EMPTY;
                end
            end
        endcase
    end

    // Result and id hold their values once drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_o1 <= 1'b0;
            rsp_id <= '0;
            ptr    <= '0;
        end else if (grant) begin
            rsp_o1 <= fn_o1;
            rsp_id <= win;
            ptr    <= nxt_ptr;
        end
    end

`ifdef FN3_SCHED_STATS_EN
    for (genvar i = 0; i < N_REQ; i++) begin : g_cnt
        logic [CNT_W-1:0] cnt_q;

        // Saturating: sticks at all-ones.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else if (req_ready[i] && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end

        assign gnt_cnt[i*CNT_W +: CNT_W] = cnt_q;
    end
`else
    // CNT_W only sizes the counters; nothing to build here.
    if (CNT_W < 1) begin : g_cnt_w_unused
    end
`endif

endmodule

// File: tb/tb_fn3_rr_sched.sv
// tb_fn3_rr_sched: directed stimulus with a response scoreboard
// for fn3_rr_sched (both default and FN3_SCHED_STATS_EN builds).
module tb_fn3_rr_sched;
    import fn3_pkg::*;

    localparam int N  = 4;
    localparam int CW = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req_valid;
    logic [N-1:0] req_ready;
    logic [N-1:0] req_a;
    logic [N-1:0] req_b;
    logic [N-1:0] req_c;
    logic [N-1:0] req_sel;
    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_o1;
    logic [1:0]   rsp_id;
`ifdef FN3_SCHED_STATS_EN
    logic [N*CW-1:0] gnt_cnt;
`endif

    always #5 clk = ~clk;

    fn3_rr_sched #(
        .N_REQ (N),
        .CNT_W (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_c     (req_c),
        .req_sel   (req_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_o1    (rsp_o1),
        .rsp_id    (rsp_id)
`ifdef FN3_SCHED_STATS_EN
        ,
        .gnt_cnt   (gnt_cnt)
`endif
    );

    typedef struct packed {
        logic [1:0] id;
        logic       o1;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic push(input int id, input logic o1);
        exp_t e;
        e.id = 2'(id);
        e.o1 = o1;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pattern a=1111 b=0101 c=0000 sel=0000: parity per requester
    // gives 0,1,0,1 for requesters 0..3.
    task automatic set_pattern();
        req_a   = 4'b1111;
        req_b   = 4'b0101;
        req_c   = 4'b0000;
        req_sel = 4'b0000;
    endtask

    function automatic logic pat_o1(input int i);
        logic [3:0] t;
        t = 4'b1010;
        return t[2'(i)];
    endfunction

    // A response retires on the next edge when valid && ready here.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL rsp_unexpected: got id=%0d o1=%0b, none queued",
                         rsp_id, rsp_o1);
            end else begin
                mon_e = sb.pop_front();
                if (rsp_id !== mon_e.id || rsp_o1 !== mon_e.o1) begin
                    bad++;
                    $display("FAIL rsp: got id=%0d o1=%0b want id=%0d o1=%0b",
                             rsp_id, rsp_o1, mon_e.id, mon_e.o1);
                end
            end
        end
    end

    initial begin
        logic [3:0] vb;

        rst_n     = 1'b0;
        req_valid = '1;
        rsp_ready = 1'b1;
        set_pattern();

        // Reset state with all requesters valid.
        repeat (2) @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_o1", 32'(rsp_o1), 32'd0);
        check("reset_rsp_id", 32'(rsp_id), 32'd0);

        // First grant after release goes to requester 0.
        rst_n = 1'b1;
        #1;
        check("first_grant_ready", 32'(req_ready), 32'b0001);
        push(0, pat_o1(0));
        tick();
        req_valid = '0;

        // Single requester 2: parity 1^1^0=0, then AND3 1&1&1=1.
        req_valid = 4'b0100;
        req_a     = 4'b0100;
        req_b     = 4'b0100;
        req_c     = 4'b0000;
        req_sel   = 4'b0000;
        push(2, 1'b0);
        tick();
        req_c     = 4'b0100;
        req_sel   = 4'b0100;
        push(2, 1'b1);
        tick();
        req_valid = '0;

        // Truth table through requester 3.
        for (int v = 0; v < 16; v++) begin
            vb        = 4'(v);
            req_valid = 4'b1000;
            req_a     = {vb[3], 3'b000};
            req_b     = {vb[2], 3'b000};
            req_c     = {vb[1], 3'b000};
            req_sel   = {vb[0], 3'b000};
            push(3, fn3_eval(vb[3], vb[2], vb[1], vb[0]));
            tick();
        end
        req_valid = '0;
        set_pattern();

        // Full load: pointer is back at 0 after the requester-3 grants.
        req_valid = '1;
        for (int k = 0; k < 9; k++) begin
            push(k % 4, pat_o1(k % 4));
        end
        for (int k = 0; k < 9; k++) begin
            @(posedge clk);
            #1;
            if (k == 8) begin
                req_valid = '0;
            end
            @(negedge clk);
            check("full_rsp_valid", 32'(rsp_valid), 32'd1);
        end
        tick();

        // Backpressure: grant 1, stall three cycles, then refill with 2.
        req_valid = '1;
        push(1, pat_o1(1));
        tick();
        rsp_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            check("stall_rsp_id", 32'(rsp_id), 32'd1);
            check("stall_rsp_o1", 32'(rsp_o1), 32'd1);
            check("stall_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        push(2, pat_o1(2));
        #1;
        check("refill_req_ready", 32'(req_ready), 32'b0100);
        tick();
        req_valid = '0;
        tick();

        // Reset during a stall discards the held response.
        rsp_ready = 1'b0;
        req_valid = 4'b1000;
        push(3, pat_o1(3));
        tick();
        req_valid = '1;
        tick();
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_rsp_id", 32'(rsp_id), 32'd0);
        check("midrst_rsp_o1", 32'(rsp_o1), 32'd0);
        check("midrst_req_ready", 32'(req_ready), 32'd0);
`ifdef FN3_SCHED_STATS_EN
        check("midrst_gnt_cnt", gnt_cnt, 32'd0);
`endif
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        #1;
        check("postrst_req_ready", 32'(req_ready), 32'b0001);
        push(0, pat_o1(0));
        tick();
        req_valid = '0;
        tick();

`ifdef FN3_SCHED_STATS_EN
        // 300 grants to requester 1 saturate its counter at 255.
        rst_n = 1'b0;
        @(negedge clk);
        check("stats_reset_cnt", gnt_cnt, 32'd0);
        rst_n     = 1'b1;
        req_valid = 4'b0010;
        req_a     = 4'b0010;
        req_b     = 4'b0000;
        req_c     = 4'b0000;
        req_sel   = 4'b0000;
        repeat (300) push(1, 1'b1);
        repeat (300) tick();
        req_valid = '0;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("stats_cnt1_sat", 32'(gnt_cnt[15:8]), 32'd255);
        check("stats_cnt_others", gnt_cnt & 32'hFFFF_00FF, 32'd0);
        tick();
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        check("stats_stall_rst_cnt", gnt_cnt, 32'd0);
        check("stats_stall_rst_valid", 32'(rsp_valid), 32'd0);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
`endif

        rsp_ready = 1'b1;
        for (int i = 0; i < 50 && sb.size() != 0; i++) begin
            @(negedge clk);
        end
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
